// File: rtl/sdr_ch_arbiter.sv
// Shares one word-addressed SDRAM channel between a priority write port (ROM loader)
// and N round-robin read ports; one transaction in flight, acks pulse in a guard cycle.
module sdr_ch_arbiter #(
    parameter int N  = 3,
    parameter int AW = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            download,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic [15:0]     wr_din,
    input  logic [1:0]      wr_be,
    output logic            wr_ack,
    input  logic [N-1:0]    rd_req,
    input  logic [N*AW-1:0] rd_addr,
    output logic [N-1:0]    rd_ack,
    output logic [15:0]     rd_dout,
    output logic [AW-2:0]   chan_addr,
    output logic [15:0]     chan_din,
    output logic [1:0]      chan_be,
    output logic            chan_rnw,
    output logic            chan_req,
    input  logic            chan_ready,
    input  logic [15:0]     chan_dout,
    output logic            busy,
    output logic [3:0]      grant_id
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [AW-2:0]   chan_addr_q, chan_addr_d;
    logic [15:0]     chan_din_q, chan_din_d;
    logic [1:0]      chan_be_q, chan_be_d;
    logic            chan_rnw_q, chan_rnw_d;
    logic            chan_req_q, chan_req_d;
    logic [3:0]      grant_id_q, grant_id_d;
    logic [15:0]     rd_dout_q, rd_dout_d;
    logic [N-1:0]    rd_ack_q, rd_ack_d;
    logic            wr_ack_q, wr_ack_d;

    logic            rd_found;
    logic [PW-1:0]   rd_win;
    logic [AW-2:0]   rd_word_sel;
    int unsigned     rr_idx;
    logic            unused_lsb;

    // Rotating search starting just after the last served read port.
    always_comb begin
        rd_found = 1'b0;
        rd_win   = '0;
        rr_idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            rr_idx = (32'(ptr_q) + k) % N;
            if (!rd_found && rd_req[PW'(rr_idx)]) begin
                rd_found = 1'b1;
                rd_win   = PW'(rr_idx);
            end
        end
    end

    always_comb begin
        rd_word_sel = '0;
        unused_lsb  = wr_addr[0];
        for (int unsigned i = 0; i < N; i++) begin
            if (PW'(i) == rd_win) begin
                rd_word_sel = rd_addr[i*AW+1 +: AW-1];
            end
            unused_lsb = unused_lsb ^ rd_addr[i*AW];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        chan_addr_d = chan_addr_q;
        chan_din_d  = chan_din_q;
        chan_be_d   = chan_be_q;
        chan_rnw_d  = chan_rnw_q;
        chan_req_d  = chan_req_q;
        grant_id_d  = grant_id_q;
        rd_dout_d   = rd_dout_q;
        rd_ack_d    = '0;
        wr_ack_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    chan_addr_d = wr_addr[AW-1:1];
                    chan_din_d  = wr_din;
                    chan_be_d   = wr_be;
                    chan_rnw_d  = 1'b0;
                    chan_req_d  = 1'b1;
                    grant_id_d  = 4'hF;
                    state_d     = S_BUSY;
                end else if (!download && rd_found) begin
                    chan_addr_d = rd_word_sel;
                    chan_be_d   = 2'b11;
                    chan_rnw_d  = 1'b1;
                    chan_req_d  = 1'b1;
                    grant_id_d  = 4'(rd_win);
                    win_d       = rd_win;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (chan_ready) begin
                    chan_req_d = 1'b0;
                    if (chan_rnw_q) begin
                        rd_dout_d = chan_dout;
                        ptr_d     = win_q;
                        for (int unsigned i = 0; i < N; i++) begin
                            rd_ack_d[i] = (win_q == PW'(i));
                        end
                    end else begin
                        wr_ack_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            // Guard cycle: acks are visible here so requesters can drop req before re-arbitration.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(N - 1);
            win_q       <= '0;
            chan_addr_q <= '0;
            chan_din_q  <= '0;
            chan_be_q   <= '0;
            chan_rnw_q  <= 1'b1;
            chan_req_q  <= 1'b0;
            grant_id_q  <= 4'hF;
            rd_dout_q   <= '0;
            rd_ack_q    <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            chan_addr_q <= chan_addr_d;
            chan_din_q  <= chan_din_d;
            chan_be_q   <= chan_be_d;
            chan_rnw_q  <= chan_rnw_d;
            chan_req_q  <= chan_req_d;
            grant_id_q  <= grant_id_d;
            rd_dout_q   <= rd_dout_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign chan_addr = chan_addr_q;
    assign chan_din  = chan_din_q;
    assign chan_be   = chan_be_q;
    assign chan_rnw  = chan_rnw_q;
    assign chan_req  = chan_req_q;
    assign grant_id  = grant_id_q;
    assign rd_dout   = rd_dout_q;
    assign rd_ack    = rd_ack_q;
    assign wr_ack    = wr_ack_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdr_ch_arbiter.sv
// Directed bench for sdr_ch_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_sdr_ch_arbiter;

    localparam int N  = 3;
    localparam int AW = 25;

    logic            clk = 1'b0;
    logic            reset;
    logic            download;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     wr_din;
    logic [1:0]      wr_be;
    logic            wr_ack;
    logic [N-1:0]    rd_req;
    logic [N*AW-1:0] rd_addr;
    logic [N-1:0]    rd_ack;
    logic [15:0]     rd_dout;
    logic [AW-2:0]   chan_addr;
    logic [15:0]     chan_din;
    logic [1:0]      chan_be;
    logic            chan_rnw;
    logic            chan_req;
    logic            chan_ready;
    logic [15:0]     chan_dout;
    logic            busy;
    logic [3:0]      grant_id;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sdr_ch_arbiter #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .download(download),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_dout(rd_dout),
        .chan_addr(chan_addr), .chan_din(chan_din), .chan_be(chan_be), .chan_rnw(chan_rnw),
        .chan_req(chan_req), .chan_ready(chan_ready), .chan_dout(chan_dout),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic do_reset();
        reset = 1'b1; download = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0;
        rd_req = '0; rd_addr = '0; chan_ready = 1'b0; chan_dout = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Polls on falling edges for chan_req, up to 20 cycles.
    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (chan_req) begin
                got = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Called on the falling edge where chan_req was first seen; returns on the falling edge where acks are visible.
    task automatic respond(input int lat, input logic [15:0] d);
        repeat (lat - 1) @(negedge clk);
        chan_ready = 1'b1;
        chan_dout  = d;
        @(negedge clk);
        chan_ready = 1'b0;
        chan_dout  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; download = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0;
        rd_req = '0; rd_addr = '0; chan_ready = 1'b0; chan_dout = '0;
        @(negedge clk);
        vectors++; if ({chan_req, busy, wr_ack, rd_ack} !== 6'b0) begin miscompares++;
            $display("FAIL reset_ctl: got req/busy/wack/rack %b want 000000", {chan_req, busy, wr_ack, rd_ack}); end
        vectors++; if (chan_rnw !== 1'b1) begin miscompares++; $display("FAIL reset_rnw: got %b want 1", chan_rnw); end
        vectors++; if (grant_id !== 4'hF) begin miscompares++; $display("FAIL reset_gid: got %h want f", grant_id); end
        vectors++; if ({chan_addr, chan_din, chan_be, rd_dout} !== '0) begin miscompares++;
            $display("FAIL reset_data: got addr %h din %h be %b dout %h want 0", chan_addr, chan_din, chan_be, rd_dout); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bit got;
        do_reset();
        rd_addr[1*AW +: AW] = 25'h000204;
        rd_req = 3'b010;
        @(negedge clk);
        wait_req(got);
        vectors++; if (!got) begin miscompares++; $display("FAIL sr_timeout: got no chan_req want chan_req"); end
        vectors++; if (chan_addr !== 24'h000102) begin miscompares++; $display("FAIL sr_addr: got %h want 000102", chan_addr); end
        vectors++; if ({chan_rnw, chan_be} !== 3'b111) begin miscompares++; $display("FAIL sr_rnw_be: got %b want 111", {chan_rnw, chan_be}); end
        vectors++; if (grant_id !== 4'd1) begin miscompares++; $display("FAIL sr_gid: got %h want 1", grant_id); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sr_busy: got %b want 1", busy); end
        respond(5, 16'hBEEF);
        vectors++; if (rd_ack !== 3'b010) begin miscompares++; $display("FAIL sr_ack: got %b want 010", rd_ack); end
        vectors++; if (rd_dout !== 16'hBEEF) begin miscompares++; $display("FAIL sr_dout: got %h want beef", rd_dout); end
        vectors++; if (chan_req !== 1'b0) begin miscompares++; $display("FAIL sr_req_drop: got %b want 0", chan_req); end
        rd_req = 3'b000;
        @(negedge clk);
        vectors++; if ({rd_ack, busy} !== 4'b0000) begin miscompares++; $display("FAIL sr_ack_len: got ack/busy %b want 0000", {rd_ack, busy}); end
        vectors++; if (rd_dout !== 16'hBEEF) begin miscompares++; $display("FAIL sr_dout_hold: got %h want beef", rd_dout); end
    endtask

    task automatic test_round_robin();
        bit got;
        int exp;
        do_reset();
        rd_addr = {25'h000300, 25'h000200, 25'h000100};
        rd_req = 3'b111;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            exp = i % 3;
            wait_req(got);
            vectors++; if (!got) begin miscompares++; $display("FAIL rr_timeout[%0d]: got no chan_req want chan_req", i); end
            vectors++; if (grant_id !== 4'(exp)) begin miscompares++; $display("FAIL rr_order[%0d]: got %h want %0d", i, grant_id, exp); end
            vectors++; if (chan_addr !== 24'(exp + 1) << 7) begin miscompares++; $display("FAIL rr_addr[%0d]: got %h want %h", i, chan_addr, 24'(exp + 1) << 7); end
            respond(2, 16'(16'hA000 + i));
            vectors++; if (rd_ack !== 3'(1 << exp)) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", i, rd_ack, 3'(1 << exp)); end
            rd_req[exp] = 1'b0;
            @(negedge clk);
            rd_req[exp] = 1'b1;
        end
        rd_req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_priority();
        bit got;
        do_reset();
        wr_addr = 25'h010000; wr_din = 16'h1234; wr_be = 2'b01; wr_req = 1'b1;
        rd_addr[0 +: AW] = 25'h000040; rd_req = 3'b001;
        @(negedge clk);
        wait_req(got);
        vectors++; if (!got) begin miscompares++; $display("FAIL wp_timeout: got no chan_req want chan_req"); end
        vectors++; if ({chan_rnw, chan_be, grant_id} !== {1'b0, 2'b01, 4'hF}) begin miscompares++;
            $display("FAIL wp_ctl: got rnw %b be %b gid %h want 0 01 f", chan_rnw, chan_be, grant_id); end
        vectors++; if ({chan_addr, chan_din} !== {24'h008000, 16'h1234}) begin miscompares++;
            $display("FAIL wp_data: got addr %h din %h want 008000 1234", chan_addr, chan_din); end
        respond(3, 16'h0000);
        vectors++; if ({wr_ack, rd_ack} !== 4'b1000) begin miscompares++; $display("FAIL wp_ack: got wack/rack %b want 1000", {wr_ack, rd_ack}); end
        wr_req = 1'b0;
        @(negedge clk);
        wait_req(got);
        vectors++; if (!got || grant_id !== 4'd0 || chan_rnw !== 1'b1 || chan_addr !== 24'h000020) begin miscompares++;
            $display("FAIL wp_read_after: got req %b gid %h rnw %b addr %h want 1 0 1 000020", got, grant_id, chan_rnw, chan_addr); end
        respond(1, 16'h4321);
        vectors++; if ({wr_ack, rd_ack, rd_dout} !== {4'b0001, 16'h4321}) begin miscompares++;
            $display("FAIL wp_read_ack: got wack/rack %b dout %h want 0001 4321", {wr_ack, rd_ack}, rd_dout); end
        rd_req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_download();
        bit got;
        bit leaked;
        do_reset();
        download = 1'b1;
        rd_addr[2*AW +: AW] = 25'h1FFFFFE; rd_req = 3'b100;
        leaked = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (chan_req !== 1'b0 || rd_ack !== 3'b000) leaked = 1'b1;
        end
        vectors++; if (leaked) begin miscompares++; $display("FAIL dl_block: got read activity during download want none"); end
        wr_addr = 25'h000ABC; wr_din = 16'h5555; wr_be = 2'b11; wr_req = 1'b1;
        @(negedge clk);
        wait_req(got);
        vectors++; if (!got || grant_id !== 4'hF || chan_addr !== 24'h00055E) begin miscompares++;
            $display("FAIL dl_write: got req %b gid %h addr %h want 1 f 00055e", got, grant_id, chan_addr); end
        respond(2, 16'h0000);
        vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL dl_wack: got %b want 1", wr_ack); end
        wr_req = 1'b0;
        leaked = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (chan_req !== 1'b0 || rd_ack !== 3'b000) leaked = 1'b1;
        end
        vectors++; if (leaked) begin miscompares++; $display("FAIL dl_block_after_wr: got read activity want none"); end
        download = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk);
            got = chan_req;
        end
        vectors++; if (!got || grant_id !== 4'd2 || chan_addr !== 24'hFFFFFF) begin miscompares++;
            $display("FAIL dl_release: got req %b gid %h addr %h want 1 2 ffffff", got, grant_id, chan_addr); end
        respond(2, 16'h7777);
        rd_req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stray();
        bit got;
        do_reset();
        chan_ready = 1'b1; chan_dout = 16'hDEAD;
        @(negedge clk);
        chan_ready = 1'b0; chan_dout = '0;
        vectors++; if ({busy, wr_ack, rd_ack, chan_req} !== 6'b0 || rd_dout !== 16'h0000) begin miscompares++;
            $display("FAIL st_idle_ready: got busy/wack/rack/req %b dout %h want 000000 0000", {busy, wr_ack, rd_ack, chan_req}, rd_dout); end
        rd_addr[0 +: AW] = 25'h000010; rd_req = 3'b001;
        @(negedge clk);
        wait_req(got);
        rd_req = 3'b000;
        respond(3, 16'h5A5A);
        vectors++; if ({rd_ack, rd_dout} !== {3'b001, 16'h5A5A}) begin miscompares++;
            $display("FAIL st_drop_ack: got rack %b dout %h want 001 5a5a", rd_ack, rd_dout); end
        rd_addr[1*AW +: AW] = 25'h000020; rd_req = 3'b010;
        @(negedge clk);
        vectors++; if ({chan_req, rd_ack} !== 4'b0000) begin miscompares++;
            $display("FAIL st_guard: got req/rack %b want 0000", {chan_req, rd_ack}); end
        @(negedge clk);
        vectors++; if (chan_req !== 1'b1 || grant_id !== 4'd1) begin miscompares++;
            $display("FAIL st_next_grant: got req %b gid %h want 1 1", chan_req, grant_id); end
        respond(1, 16'h1111);
        rd_req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        bit got;
        bit stray;
        do_reset();
        rd_addr = {25'h000600, 25'h000400, 25'h000200};
        rd_req = 3'b001;
        @(negedge clk);
        wait_req(got);
        respond(1, 16'h0101);
        rd_req = 3'b010;
        @(negedge clk);
        wait_req(got);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if ({chan_req, busy, chan_rnw, grant_id} !== {3'b001, 4'hF}) begin miscompares++;
            $display("FAIL rm_async: got req %b busy %b rnw %b gid %h want 0 0 1 f", chan_req, busy, chan_rnw, grant_id); end
        rd_req = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        chan_ready = 1'b1; chan_dout = 16'hBAD0;
        @(negedge clk);
        chan_ready = 1'b0;
        stray = (rd_ack !== 3'b000) || (wr_ack !== 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (rd_ack !== 3'b000 || wr_ack !== 1'b0) stray = 1'b1;
        end
        vectors++; if (stray) begin miscompares++; $display("FAIL rm_no_ack: got ack after reset want none"); end
        rd_req = 3'b011;
        @(negedge clk);
        wait_req(got);
        vectors++; if (!got || grant_id !== 4'd0) begin miscompares++;
            $display("FAIL rm_first_grant: got req %b gid %h want 1 0", got, grant_id); end
        respond(1, 16'h0000);
        rd_req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_download();
        test_stray();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
